// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point radix-4 FFT frame sequencer:
// frame geometry, sequencer states, index reversal and frame-bus slot helpers.
package fft16_pkg;

  localparam int N     = 16;
  localparam int LOG4N = 2;
  localparam int IDX_W = 2 * LOG4N;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  // Swap the two base-4 digits of a frequency index.
  function automatic logic [IDX_W-1:0] digit_rev4(input logic [IDX_W-1:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

  // LSB of sample `slot` inside a packed N*dw frame bus.
  function automatic int slot_lo(input int slot, input int dw);
    return slot * dw;
  endfunction

endpackage

// File: rtl/fft16_frame_ctrl_if.sv
// Serial sample streams of the FFT frame sequencer: input samples in, spectrum out.
interface fft16_frame_ctrl_if #(
  parameter int DW = 16
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [3:0]    out_idx;
  logic          out_last;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft16_unloader.sv
// Result buffer plus serial unload port: holds one captured result frame and
// streams it out under valid/ready, optionally in base-4 digit-reversed read order.
module fft16_unloader
  import fft16_pkg::*;
#(
  parameter int DW      = 16,
  parameter int REORDER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             capture_i,
  input  logic             active_i,
  input  logic [N*DW-1:0]  res_re_i,
  input  logic [N*DW-1:0]  res_im_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [DW-1:0]    out_re_o,
  output logic [DW-1:0]    out_im_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             done_o
);

  logic [DW-1:0]    res_re_q [N];
  logic [DW-1:0]    res_im_q [N];
  logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0] rd_sel;
  logic             handshake;

  generate
    if (REORDER != 0) begin : g_rev
      assign rd_sel = digit_rev4(rd_cnt_q);
    end else begin : g_nat
      assign rd_sel = rd_cnt_q;
    end
  endgenerate

  // Output data is forced to zero outside UNLOAD so reset values hold without clearing the buffer.
  assign out_valid_o = active_i;
  assign handshake   = active_i & out_ready_i;
  assign done_o      = handshake & (rd_cnt_q == IDX_W'(N - 1));
  assign out_re_o    = active_i ? res_re_q[rd_sel] : '0;
  assign out_im_o    = active_i ? res_im_q[rd_sel] : '0;
  assign out_idx_o   = rd_cnt_q;
  assign out_last_o  = active_i & (rd_cnt_q == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (capture_i) begin
      for (int i = 0; i < N; i++) begin
        res_re_q[i] <= res_re_i[slot_lo(i, DW) +: DW];
        res_im_q[i] <= res_im_i[slot_lo(i, DW) +: DW];
      end
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (flush_i) begin
      rd_cnt_d = '0;
    end else if (handshake) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT datapath: serial load into a parallel
// operand frame, fixed-latency wait, result capture and serial unload.
module fft16_frame_ctrl
  import fft16_pkg::*;
#(
  parameter int DW       = 16,
  parameter int PIPE_LAT = 4,
  parameter int REORDER  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  fft16_frame_ctrl_if.slave  bus,
  output logic [N*DW-1:0]    dp_re,
  output logic [N*DW-1:0]    dp_im,
  output logic               dp_start,
  input  logic [N*DW-1:0]    dp_res_re,
  input  logic [N*DW-1:0]    dp_res_im,
  output logic               busy
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [3:0]       lat_cnt_q, lat_cnt_d;
  logic             dp_start_q, dp_start_d;
  logic [DW-1:0]    op_re_q [N];
  logic [DW-1:0]    op_im_q [N];
  logic             in_accept;
  logic             capture;
  logic             unload_done;

  assign bus.in_ready = (state_q == LOAD);
  assign in_accept    = bus.in_valid & bus.in_ready;
  assign capture      = (state_q == RUN) & (lat_cnt_q == 4'(PIPE_LAT - 1)) & ~flush;
  assign busy         = (state_q != LOAD);
  assign dp_start     = dp_start_q;

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    dp_start_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_accept) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == IDX_W'(N - 1)) begin
            state_d    = RUN;
            lat_cnt_d  = '0;
            dp_start_d = 1'b1;
          end
        end
      end
      RUN: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (capture) begin
          state_d   = UNLOAD;
          lat_cnt_d = '0;
        end
      end
      UNLOAD: begin
        if (unload_done) begin
          state_d  = LOAD;
          wr_cnt_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
    // Abort wins over every transition, including a completing load.
    if (flush) begin
      state_d    = LOAD;
      wr_cnt_d   = '0;
      lat_cnt_d  = '0;
      dp_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      wr_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      dp_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      dp_start_q <= dp_start_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        op_re_q[i] <= '0;
        op_im_q[i] <= '0;
      end
    end else if (in_accept && !flush) begin
      op_re_q[wr_cnt_q] <= bus.in_re;
      op_im_q[wr_cnt_q] <= bus.in_im;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign dp_re[slot_lo(gi, DW) +: DW] = op_re_q[gi];
      assign dp_im[slot_lo(gi, DW) +: DW] = op_im_q[gi];
    end
  endgenerate

  fft16_unloader #(
    .DW      (DW),
    .REORDER (REORDER)
  ) u_unloader (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .capture_i   (capture),
    .active_i    (state_q == UNLOAD),
    .res_re_i    (dp_res_re),
    .res_im_i    (dp_res_im),
    .out_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .out_re_o    (bus.out_re),
    .out_im_o    (bus.out_im),
    .out_idx_o   (bus.out_idx),
    .out_last_o  (bus.out_last),
    .done_o      (unload_done)
  );

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Bench for fft16_frame_ctrl: two instances (digit-reversed and natural unload) share
// stimulus and a latency-PIPE_LAT datapath model; outputs are checked against queues.
`timescale 1ns/1ps
module tb_fft16_frame_ctrl;
  import fft16_pkg::*;

  localparam int DW       = 16;
  localparam int PIPE_LAT = 4;
  localparam int NREG     = PIPE_LAT - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          tb_in_valid = 1'b0;
  logic          tb_out_ready = 1'b0;
  logic [DW-1:0] tb_in_re = '0;
  logic [DW-1:0] tb_in_im = '0;

  always #5 clk = ~clk;

  fft16_frame_ctrl_if #(.DW(DW)) bus0 ();
  fft16_frame_ctrl_if #(.DW(DW)) bus1 ();

  assign bus0.in_valid  = tb_in_valid;
  assign bus0.in_re     = tb_in_re;
  assign bus0.in_im     = tb_in_im;
  assign bus0.out_ready = tb_out_ready;
  assign bus1.in_valid  = tb_in_valid;
  assign bus1.in_re     = tb_in_re;
  assign bus1.in_im     = tb_in_im;
  assign bus1.out_ready = tb_out_ready;

  logic [N*DW-1:0] dp_re0, dp_im0, dp_re1, dp_im1, res_re, res_im;
  logic            dp_start0, dp_start1, busy0, busy1;

  fft16_frame_ctrl #(.DW(DW), .PIPE_LAT(PIPE_LAT), .REORDER(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0),
    .dp_re(dp_re0), .dp_im(dp_im0), .dp_start(dp_start0),
    .dp_res_re(res_re), .dp_res_im(res_im), .busy(busy0)
  );

  fft16_frame_ctrl #(.DW(DW), .PIPE_LAT(PIPE_LAT), .REORDER(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1),
    .dp_re(dp_re1), .dp_im(dp_im1), .dp_start(dp_start1),
    .dp_res_re(res_re), .dp_res_im(res_im), .busy(busy1)
  );

  // Datapath model: mode 0 = per-slot transform, 1 = impulse spectrum, 2 = slot index.
  int              dp_mode = 0;
  logic [N*DW-1:0] st0_re, st0_im;
  logic [N*DW-1:0] pipe_re [NREG];
  logic [N*DW-1:0] pipe_im [NREG];

  always_comb begin
    st0_re = '0;
    st0_im = '0;
    for (int j = 0; j < N; j++) begin
      case (dp_mode)
        1: begin
          st0_re[j*DW +: DW] = dp_re0[0 +: DW];
          st0_im[j*DW +: DW] = dp_im0[0 +: DW];
        end
        2: begin
          st0_re[j*DW +: DW] = DW'(j);
          st0_im[j*DW +: DW] = ~DW'(j);
        end
        default: begin
          st0_re[j*DW +: DW] = dp_re0[j*DW +: DW] ^ 16'h5A5A;
          st0_im[j*DW +: DW] = dp_im0[j*DW +: DW];
        end
      endcase
    end
  end

  always @(posedge clk) begin
    pipe_re[0] <= st0_re;
    pipe_im[0] <= st0_im;
    for (int k = 1; k < NREG; k++) begin
      pipe_re[k] <= pipe_re[k-1];
      pipe_im[k] <= pipe_im[k-1];
    end
  end
  assign res_re = pipe_re[NREG-1];
  assign res_im = pipe_im[NREG-1];

  int start_cnt = 0;
  always @(posedge clk) if (dp_start0) start_cnt <= start_cnt + 1;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fr_re [N];
  logic [DW-1:0] fr_im [N];
  logic [DW-1:0] q_re[$], q_im[$], q1_re[$], q1_im[$];
  logic [3:0]    q_idx[$];

  task automatic clear_queues();
    q_re.delete(); q_im.delete(); q1_re.delete(); q1_im.delete(); q_idx.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = DW'($urandom);
      fr_im[i] = DW'($urandom);
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < N; k++) begin
      int dr;
      dr = ((k % 4) * 4) + (k / 4);
      q_idx.push_back(4'(k));
      case (dp_mode)
        1: begin
          q_re.push_back(fr_re[0]);  q_im.push_back(fr_im[0]);
          q1_re.push_back(fr_re[0]); q1_im.push_back(fr_im[0]);
        end
        2: begin
          q_re.push_back(DW'(dr));   q_im.push_back(~DW'(dr));
          q1_re.push_back(DW'(k));   q1_im.push_back(~DW'(k));
        end
        default: begin
          q_re.push_back(fr_re[dr] ^ 16'h5A5A); q_im.push_back(fr_im[dr]);
          q1_re.push_back(fr_re[k] ^ 16'h5A5A); q1_im.push_back(fr_im[k]);
        end
      endcase
    end
  endtask

  // Ends at the falling edge right after the last accept (or the flushed accept).
  task automatic send_frame(input int duty, input int flush_at, input bit push);
    int i = 0;
    int guard = 0;
    bit v, acc;
    @(negedge clk);
    while (i < N && guard < 2000) begin
      v = (duty >= 100) || ($urandom_range(0, 99) < duty) || (i == flush_at);
      tb_in_valid = v;
      tb_in_re    = fr_re[i];
      tb_in_im    = fr_im[i];
      acc         = v && bus0.in_ready;
      flush       = acc && (i == flush_at);
      @(negedge clk);
      flush = 1'b0;
      if (acc) begin
        if (i == flush_at) break;
        i++;
      end
      guard++;
    end
    tb_in_valid = 1'b0;
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL send_timeout: accepted %0d samples, required %0d", i, N);
    end
    if (push && flush_at < 0) push_expected();
  endtask

  task automatic recv_frame(input int rdy_pct, input int flush_at, input int stop_after);
    int            n = 0;
    int            guard = 0;
    bit            stalled = 1'b0;
    bit            rdy, fl, e_last;
    logic [DW-1:0] p_re = '0;
    logic [DW-1:0] p_im = '0;
    logic [3:0]    p_idx = '0;
    while (n < stop_after && guard < 3000) begin
      if (bus0.out_valid === 1'b1) begin
        if (stalled) begin
          checks++;
          if (bus0.out_re !== p_re || bus0.out_im !== p_im || bus0.out_idx !== p_idx) begin
            errors++;
            $display("FAIL stall_hold: got re=%h im=%h idx=%0d, required re=%h im=%h idx=%0d",
                     bus0.out_re, bus0.out_im, bus0.out_idx, p_re, p_im, p_idx);
          end
        end
        checks++;
        if (bus0.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_unload: got %b, required 0", bus0.in_ready);
        end
        fl  = (n == flush_at);
        rdy = fl ? (flush_at == N - 1) : ((rdy_pct >= 100) || ($urandom_range(0, 99) < rdy_pct));
        tb_out_ready = rdy;
        flush        = fl;
        if (rdy) begin
          checks++;
          if (q_re.size() == 0) begin
            errors++;
            $display("FAIL extra_output: got re=%h idx=%0d, required no output", bus0.out_re, bus0.out_idx);
          end else begin
            e_last = (q_idx[0] == 4'hF);
            if (bus0.out_re !== q_re[0] || bus0.out_im !== q_im[0] ||
                bus0.out_idx !== q_idx[0] || bus0.out_last !== e_last) begin
              errors++;
              $display("FAIL out_sample: got re=%h im=%h idx=%0d last=%b, required re=%h im=%h idx=%0d last=%b",
                       bus0.out_re, bus0.out_im, bus0.out_idx, bus0.out_last,
                       q_re[0], q_im[0], q_idx[0], e_last);
            end
            checks++;
            if (bus1.out_valid !== 1'b1 || bus1.out_re !== q1_re[0] || bus1.out_im !== q1_im[0]) begin
              errors++;
              $display("FAIL out_natural: got valid=%b re=%h im=%h, required valid=1 re=%h im=%h",
                       bus1.out_valid, bus1.out_re, bus1.out_im, q1_re[0], q1_im[0]);
            end
            void'(q_re.pop_front()); void'(q_im.pop_front()); void'(q_idx.pop_front());
            void'(q1_re.pop_front()); void'(q1_im.pop_front());
          end
          n++;
        end
        stalled = !rdy;
        p_re    = bus0.out_re;
        p_im    = bus0.out_im;
        p_idx   = bus0.out_idx;
        @(negedge clk);
        flush = 1'b0;
        if (fl) break;
      end else begin
        tb_out_ready = (rdy_pct >= 100) || ($urandom_range(0, 99) < rdy_pct);
        stalled = 1'b0;
        @(negedge clk);
      end
      guard++;
    end
    tb_out_ready = 1'b0;
    if (guard >= 3000) begin
      checks++; errors++;
      $display("FAIL recv_timeout: got %0d outputs, required %0d", n, stop_after);
    end
  endtask

  task automatic clean_frame(input int duty, input int rdy_pct);
    fill_random();
    dp_mode = 0;
    send_frame(duty, -1, 1'b1);
    recv_frame(rdy_pct, -1, N);
    checks++;
    if (q_re.size() != 0) begin
      errors++;
      $display("FAIL frame_complete: got %0d outputs missing, required 0", q_re.size());
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL %s: got in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               name, bus0.in_ready, bus0.out_valid, busy0);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0 || bus0.out_last !== 1'b0 ||
        bus0.out_idx !== 4'd0 || dp_start0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b last=%b idx=%0d start=%b busy=%b, required 1 0 0 0 0 0",
               bus0.in_ready, bus0.out_valid, bus0.out_last, bus0.out_idx, dp_start0, busy0);
    end
    checks++;
    if (bus0.out_re !== '0 || bus0.out_im !== '0 || dp_re0 !== '0 || dp_im0 !== '0) begin
      errors++;
      $display("FAIL reset_data: got out_re=%h out_im=%h dp nonzero=%b, required zeros",
               bus0.out_re, bus0.out_im, (dp_re0 != '0) || (dp_im0 != '0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_impulse();
    int lat = 0;
    for (int i = 0; i < N; i++) begin fr_re[i] = '0; fr_im[i] = '0; end
    fr_re[0] = 16'h1000;
    dp_mode  = 1;
    send_frame(100, -1, 1'b1);
    checks++;
    if (dp_start0 !== 1'b1) begin
      errors++;
      $display("FAIL dp_start_timing: got %b after last accept, required 1", dp_start0);
    end
    while (bus0.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != PIPE_LAT) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d edges, required %0d", lat, PIPE_LAT);
    end
    recv_frame(100, -1, N);
    checks++;
    if (q_re.size() != 0) begin
      errors++;
      $display("FAIL impulse_count: got %0d outputs missing, required 0", q_re.size());
    end
  endtask

  task automatic test_reorder();
    fill_random();
    dp_mode = 2;
    send_frame(100, -1, 1'b1);
    recv_frame(100, -1, N);
    checks++;
    if (q_re.size() != 0) begin
      errors++;
      $display("FAIL reorder_count: got %0d outputs missing, required 0", q_re.size());
    end
  endtask

  task automatic test_backpressure();
    clean_frame(100, 40);
    clean_frame(100, 25);
  endtask

  task automatic test_input_gaps();
    logic [N*DW-1:0] e_re, e_im;
    int s0;
    fill_random();
    dp_mode = 0;
    s0 = start_cnt;
    send_frame(50, -1, 1'b1);
    for (int i = 0; i < N; i++) begin
      e_re[i*DW +: DW] = fr_re[i];
      e_im[i*DW +: DW] = fr_im[i];
    end
    checks++;
    if (dp_re0 !== e_re || dp_im0 !== e_im) begin
      errors++;
      $display("FAIL operand_frame: got re[0]=%h re[15]=%h, required re[0]=%h re[15]=%h",
               dp_re0[0 +: DW], dp_re0[15*DW +: DW], fr_re[0], fr_re[15]);
    end
    recv_frame(100, -1, N);
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL dp_start_count: got %0d pulses, required 1", start_cnt - s0);
    end
  endtask

  task automatic test_flush_input();
    fill_random();
    dp_mode = 0;
    send_frame(100, 9, 1'b0);
    check_idle("flush_input10");
    clean_frame(100, 100);
    fill_random();
    send_frame(100, 15, 1'b0);
    check_idle("flush_input16");
    checks++;
    if (dp_start0 !== 1'b0) begin
      errors++;
      $display("FAIL flush16_start: got dp_start=%b, required 0", dp_start0);
    end
    clean_frame(100, 100);
  endtask

  task automatic test_flush_run();
    bit seen = 1'b0;
    fill_random();
    dp_mode = 0;
    send_frame(100, -1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle("flush_run");
    repeat (PIPE_LAT + 2) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_run_quiet: got out_valid=1 after flush, required 0");
    end
    clean_frame(100, 100);
  endtask

  task automatic test_flush_output();
    fill_random();
    dp_mode = 0;
    send_frame(100, -1, 1'b1);
    recv_frame(100, 6, N);
    check_idle("flush_output7");
    clear_queues();
    clean_frame(100, 100);
    fill_random();
    send_frame(100, -1, 1'b1);
    recv_frame(100, N - 1, N);
    check_idle("flush_last_handshake");
    checks++;
    if (q_re.size() != 0) begin
      errors++;
      $display("FAIL flush_last_count: got %0d outputs missing, required 0", q_re.size());
    end
    clean_frame(100, 100);
  endtask

  task automatic test_async_reset();
    fill_random();
    dp_mode = 0;
    send_frame(100, -1, 1'b1);
    recv_frame(100, -1, 5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_re !== '0 || bus0.out_im !== '0 ||
        bus0.out_idx !== 4'd0 || bus0.out_last !== 1'b0 || bus0.in_ready !== 1'b1 ||
        busy0 !== 1'b0 || dp_start0 !== 1'b0 || dp_re0 !== '0) begin
      errors++;
      $display("FAIL async_reset: got vld=%b re=%h im=%h idx=%0d rdy=%b busy=%b, required 0 0 0 0 1 0",
               bus0.out_valid, bus0.out_re, bus0.out_im, bus0.out_idx, bus0.in_ready, busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    clean_frame(60, 60);
  endtask

  task automatic test_back_to_back();
    clean_frame(100, 100);
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got in_ready=%b after last output, required 1", bus0.in_ready);
    end
    clean_frame(100, 100);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_reorder();
    test_backpressure();
    test_input_gaps();
    test_flush_input();
    test_flush_run();
    test_flush_output();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft16_frame_ctrl.md
# fft16_frame_ctrl

Frame sequencer for the 16-point radix-4 FFT datapath (first-stage plus second-stage butterfly banks). It accepts 16 complex samples serially and holds them as a parallel operand frame for the datapath. It waits the datapath's fixed pipeline latency, captures the 16 results, and streams them out serially in natural frequency order. One frame is in flight at a time; there is no overlap of load and unload.

## Interface
Parameters:
- DW, 16: sample component width (two's complement), re and im each.
- PIPE_LAT, 4: clk cycles from a stable operand frame to valid datapath results; legal range 1..15.
- REORDER, 1: 1 = unload in base-4 digit-reversed read order (natural frequency order out); 0 = unload result index k directly.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards the current frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_re, in_im  in  DW  input sample components.
- dp_re, dp_im  out  16*DW  operand frame to the datapath; sample i occupies bits [i*DW +: DW].
- dp_start  out  1  one-cycle pulse on the first cycle the operand frame is stable.
- dp_res_re, dp_res_im  in  16*DW  datapath results, same packing.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re, out_im  out  DW  output sample components.
- out_idx  out  4  frequency index of the current output sample.
- out_last  out  1  high with out_idx == 15.
- busy  out  1  high in RUN or UNLOAD.

## Operation
States:
- LOAD: in_ready=1. Each accepted sample (in_valid & in_ready) is written to operand slot wr_cnt, then wr_cnt increments. The accept with wr_cnt==15 moves to RUN and pulses dp_start on the next cycle.
- RUN: in_ready=0. dp_re/dp_im are held constant. lat_cnt counts from 0. When lat_cnt == PIPE_LAT-1, dp_res_* are captured into the result buffer and the state moves to UNLOAD.
- UNLOAD: out_valid=1. out_re/out_im come from result slot rd_sel. rd_sel = {rd_cnt[1:0], rd_cnt[3:2]} when REORDER=1, otherwise rd_cnt. out_idx = rd_cnt. Each handshake (out_valid & out_ready) increments rd_cnt. The handshake with rd_cnt==15 returns to LOAD with wr_cnt=0.
- While out_valid=1 and out_ready=0, out_* hold stable (no drop, no change).
- flush has priority over every transition. On flush, the next state is LOAD with all counters 0, out_valid=0, and dp_start=0. The operand and result buffers are not cleared.
- No arithmetic is performed in this block; samples pass through bit-exact.

## Timing
- Reset values: in_ready=1 (state LOAD), out_valid=0, out_last=0, out_idx=0, dp_start=0, busy=0, out_re=out_im=0, dp_re=dp_im=0. All counters are 0.
- Last input accept at edge T:
  - dp_start is high in cycle T+1.
  - Capture occurs at edge T+PIPE_LAT.
  - out_valid first rises in cycle T+PIPE_LAT+1.
- Minimum frame period with out_ready held at 1 is 16 + PIPE_LAT + 16 cycles.
- in_ready is combinational from state only, not from in_valid.
- rst_n assertion mid-frame clears everything immediately. The first accept after rst_n deassertion is slot 0.
- flush in the same cycle as the 16th input accept: the accept is discarded and the block stays in LOAD.
- flush in the same cycle as the final output handshake: the handshake completes downstream, and the block returns to LOAD as normal.

## Structure
- Shared package fft16_pkg holds:
  - N=16 and LOG4N=2;
  - the state enum {LOAD, RUN, UNLOAD};
  - a function digit_rev4(idx) returning {idx[1:0], idx[3:2]};
  - pack/unpack helpers for the 16*DW frame buses.
- One sub-module, fft16_unloader, is natural: it contains the result buffer, rd_cnt, the reorder mux and the out_* valid/ready logic. The top level keeps the FSM, the operand buffer and lat_cnt.

## Test plan
- Impulse: send re=0x1000, im=0 at slot 0 and zero elsewhere. Use a bench model of the datapath with latency PIPE_LAT. Required: 16 outputs, each re=0x1000, im=0; out_idx 0..15; out_last on the 16th; first out_valid exactly PIPE_LAT+1 cycles after the last accept.
- Reorder: bench datapath returns result slot j = j (re=j, im=~j). Required: with REORDER=1 the out_re sequence is 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; with REORDER=0 it is 0..15.
- Backpressure: out_ready toggles pseudo-randomly. Required: no out_* change while stalled, no lost or duplicated samples, in_ready=0 until out_last is accepted.
- Input gaps: in_valid at 50% duty. Required: the operand frame on dp_re/dp_im equals the inputs in order, and dp_start fires exactly once per frame.
- flush at the 10th input, then in mid-RUN, then at the 7th output. Required: the next cycle is in_ready=1 with out_valid=0, and the following clean frame produces correct results.
- rst_n pulsed low mid-UNLOAD, asynchronously between edges. Required: out_valid drops immediately, all outputs take their reset values, and a subsequent frame is correct.
